receiver: RTL and testbench
===========================

// Module: receiver
// PURPOSE
//  SPI receiver (peripheral side) for the SPI link driven by our transmitter.
//  Oversamples CS/SCK/MOSI in the clk_100 domain and shifts in P_DATA_WIDTH-bit words, MSB first.
//  Presents each word on a valid/ready output holding register; flags overrun and aborted frames.
// PARAMETERS
//  P_DATA_WIDTH   8  word length in bits (>=2)
//  P_CS_POLAR     0  CS level meaning "selected" (0 = active-low, 1 = active-high)
//  P_SAMPLE_EDGE  0  SCK edge that samples MOSI (0 = rising, 1 = falling)
//  P_SYNC_STAGES  2  flip-flop synchroniser depth on SCK/CS/MOSI (>=2)
// PORTS
//  clk_100    in   1             system clock, 100 MHz
//  s_rst      in   1             synchronous active-high reset
//  SCK        in   1             serial clock from transmitter, asynchronous to clk_100
//  CS         in   1             chip select, polarity per P_CS_POLAR
//  MOSI       in   1             serial data, MSB first
//  data       out  P_DATA_WIDTH  received word, stable while valid=1
//  valid      out  1             data holds an unconsumed word
//  ready      in   1             consumer accepts data on a clk_100 edge with valid&&ready
//  overrun    out  1             1-cycle pulse: word completed while the holding register was full
//  frame_err  out  1             1-cycle pulse: CS deselected with 1..P_DATA_WIDTH-1 bits shifted in
// BEHAVIOUR
//  - Reset: data=0, valid=0, overrun=0, frame_err=0, FSM=IDLE, bit count=0, shift reg=0.
//    Synchroniser flops reset to the inactive CS level and SCK=0.
//  - Input path: each input passes P_SYNC_STAGES flops; one more register holds the previous SCK
//    value for edge detection. Sample edge = sync'd SCK transition matching P_SAMPLE_EDGE.
//  - SCK high and low phases must each be >= P_SYNC_STAGES+1 clk_100 cycles. Faster SCK is out of contract.
//  - FSM IDLE: wait for CS selected, then go to SHIFT with bit count 0.
//  - FSM SHIFT: on each sample edge, shift reg <= {shift reg[W-2:0], MOSI_sync} and increment the count.
//    * When the count reaches P_DATA_WIDTH, the word is complete. Reset the count to 0 and stay in
//      SHIFT, so back-to-back words work under one CS assertion.
//    * If CS is deselected: with count != 0, pulse frame_err and discard the partial word.
//      Then go to IDLE either way.
//    * CS deselect and a sample edge in the same cycle: the deselect wins and the edge is ignored.
//  - Sample edges seen while in IDLE are ignored.
//  - Word completion at cycle t: at clk edge t+1, data <= word and valid <= 1.
//    Latency from the sync'd sample edge is 1 cycle.
//  - Output handshake: valid clears on the cycle after valid&&ready, unless a new word loads then.
//    * Completion with valid=0: load the word.
//    * Completion with valid=1 and ready=1 in the same cycle: load the new word, valid stays 1.
//    * Completion with valid=1 and ready=0: drop the new word, keep data, pulse overrun for 1 cycle.
//  - data never changes while valid=1 && ready=0.
//  - s_rst asserted mid-frame: abort immediately to the reset state. No frame_err, no valid.
//    After release, a frame only starts after CS is seen deselected and then selected again.
// TESTING
//  1 Reset, CS active-low, send 0xF0 with ready=1 -> one valid cycle with data=0xF0; overrun=frame_err=0.
//  2 One CS frame carrying 0xA5 then 0x3C, ready=1 -> valid pulses twice; data 0xA5 then 0x3C, in order.
//  3 ready=0, send 0x11 then 0x22 -> data holds 0x11 with valid=1; overrun pulses once;
//    raise ready -> 0x11 is consumed and valid drops.
//  4 Deselect CS after 3 bits, then send a full 0x5A frame -> frame_err pulses once, no valid
//    for the partial word, then data=0x5A.
//  5 Assert s_rst after 4 bits of 0xFF, release, then send a new 0x81 frame -> all outputs 0
//    during reset; next valid has data=0x81.
//  6 Set P_CS_POLAR=1 and P_SAMPLE_EDGE=1, send 0xC3 -> data=0xC3; edges while CS=0 are ignored.

Source files
------------

// File: rtl/receiver.sv
// SPI peripheral-side receiver: oversamples CS/SCK/MOSI in the clk_100 domain and
// shifts in MSB-first words. Each word is presented on a valid/ready holding register.
module receiver #(
  parameter int P_DATA_WIDTH  = 8,
  parameter bit P_CS_POLAR    = 1'b0,
  parameter bit P_SAMPLE_EDGE = 1'b0,
  parameter int P_SYNC_STAGES = 2
) (
  input  logic                    clk_100,
  input  logic                    s_rst,
  input  logic                    SCK,
  input  logic                    CS,
  input  logic                    MOSI,
  output logic [P_DATA_WIDTH-1:0] data,
  output logic                    valid,
  input  logic                    ready,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam int              CW         = $clog2(P_DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_BIT   = CW'(P_DATA_WIDTH - 1);
  localparam int              FW         = $clog2(P_SYNC_STAGES + 1);
  localparam logic [FW-1:0]   FLUSH_DONE = FW'(P_SYNC_STAGES);

  logic [P_SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [P_SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [P_SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                     sck_prev_q, sck_prev_d;
  logic [0:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [P_DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [P_DATA_WIDTH-1:0]  data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic                     frame_err_q, frame_err_d;
  logic                     arm_q, arm_d;
  logic [FW-1:0]            flush_q, flush_d;

  logic                     sck_s;
  logic                     cs_sel;
  logic                     mosi_s;
  logic                     sample_edge;
  logic                     word_done;
  logic [P_DATA_WIDTH-1:0]  next_word;

  assign sck_s       = sck_sync_q[P_SYNC_STAGES-1];
  assign cs_sel      = (cs_sync_q[P_SYNC_STAGES-1] == P_CS_POLAR);
  assign mosi_s      = mosi_sync_q[P_SYNC_STAGES-1];
  assign sample_edge = P_SAMPLE_EDGE ? (sck_prev_q & ~sck_s) : (~sck_prev_q & sck_s);
  assign next_word   = {shift_q[P_DATA_WIDTH-2:0], mosi_s};

  always_comb begin
    sck_sync_d  = {sck_sync_q[P_SYNC_STAGES-2:0], SCK};
    cs_sync_d   = {cs_sync_q[P_SYNC_STAGES-2:0], CS};
    mosi_sync_d = {mosi_sync_q[P_SYNC_STAGES-2:0], MOSI};
    sck_prev_d  = sck_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    arm_d       = arm_q;
    flush_d     = flush_q;
    word_done   = 1'b0;

    // The synchroniser comes out of reset showing "deselected", so a deselect only
    // counts once real CS samples have propagated through every stage.
    if (flush_q != FLUSH_DONE) begin
      flush_d = flush_q + FW'(1);
    end else if (!cs_sel) begin
      arm_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_sel && arm_q) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        if (!cs_sel) begin
          frame_err_d = (cnt_q != '0);
          state_d     = ST_IDLE;
          cnt_d       = '0;
          shift_d     = '0;
        end else if (sample_edge) begin
          shift_d = next_word;
          if (cnt_q == LAST_BIT) begin
            cnt_d     = '0;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A full holding register only accepts a new word if it is being drained this cycle.
    if (word_done) begin
      if (!valid_q || ready) begin
        data_d  = next_word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= {P_SYNC_STAGES{~P_CS_POLAR}};
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      arm_q       <= 1'b0;
      flush_q     <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      arm_q       <= arm_d;
      flush_q     <= flush_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_receiver.sv
// Testbench for receiver: two instances (active-low CS / rising sample, and
// active-high CS / falling sample) share SCK/MOSI and are checked against a queue model.
module tb_receiver;

  logic       clk = 1'b0;
  logic       s_rst;
  logic       sck;
  logic       mosi;
  logic       cs0;
  logic       cs1;
  logic       ready;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       overrun0, overrun1;
  logic       ferr0, ferr1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] got0[$];
  logic [7:0] got1[$];
  logic [7:0] exp0[$];
  int ov_cnt0   = 0;
  int ov_cnt1   = 0;
  int ferr_cnt0 = 0;
  int ferr_cnt1 = 0;

  // Reference model state: one-deep holding register seen from outside.
  bit         model_full = 1'b0;
  logic [7:0] model_held = 8'h00;
  int         exp_ov0    = 0;
  int         exp_ferr0  = 0;

  receiver #(
    .P_DATA_WIDTH(8), .P_CS_POLAR(1'b0), .P_SAMPLE_EDGE(1'b0), .P_SYNC_STAGES(2)
  ) dut0 (
    .clk_100(clk), .s_rst(s_rst), .SCK(sck), .CS(cs0), .MOSI(mosi),
    .data(data0), .valid(valid0), .ready(ready), .overrun(overrun0), .frame_err(ferr0)
  );

  receiver #(
    .P_DATA_WIDTH(8), .P_CS_POLAR(1'b1), .P_SAMPLE_EDGE(1'b1), .P_SYNC_STAGES(2)
  ) dut1 (
    .clk_100(clk), .s_rst(s_rst), .SCK(sck), .CS(cs1), .MOSI(mosi),
    .data(data1), .valid(valid1), .ready(ready), .overrun(overrun1), .frame_err(ferr1)
  );

  always #5 clk = ~clk;

  // Record handshakes and pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid0 && ready) got0.push_back(data0);
    if (valid1 && ready) got1.push_back(data1);
    if (overrun0) ov_cnt0   <= ov_cnt0 + 1;
    if (overrun1) ov_cnt1   <= ov_cnt1 + 1;
    if (ferr0)    ferr_cnt0 <= ferr_cnt0 + 1;
    if (ferr1)    ferr_cnt1 <= ferr_cnt1 + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Mode 0: data set up, then rising sample edge. Mode 1: rising launch, falling sample edge.
  task automatic sendBit(input logic b, input bit mode);
    int lo, hi;
    lo = $urandom_range(6, 3);
    hi = $urandom_range(6, 3);
    if (!mode) begin
      mosi = b;
      waitCycles(lo);
      sck = 1'b1;
      waitCycles(hi);
      sck = 1'b0;
    end else begin
      sck  = 1'b1;
      mosi = b;
      waitCycles(hi);
      sck = 1'b0;
      waitCycles(lo);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] word, input bit mode);
    for (int i = 7; i >= 0; i--) sendBit(word[i], mode);
    waitCycles(4);
  endtask

  // Model: a completed word is taken at once when ready is high, held when the
  // register is empty, otherwise dropped with an overrun.
  task automatic modelWord(input logic [7:0] w);
    if (ready) begin
      exp0.push_back(w);
    end else if (!model_full) begin
      model_full = 1'b1;
      model_held = w;
    end else begin
      exp_ov0++;
    end
  endtask

  task automatic raiseReady();
    ready = 1'b1;
    if (model_full) begin
      exp0.push_back(model_held);
      model_full = 1'b0;
    end
  endtask

  task automatic checkQueue(input string tag);
    checkOutput({tag, "_count"}, 32'(got0.size()), 32'(exp0.size()));
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      checkOutput($sformatf("%s_word%0d", tag, i), 32'(got0[i]), 32'(exp0[i]));
  endtask

  initial begin
    logic [7:0] w;
    s_rst = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    cs0   = 1'b1;
    cs1   = 1'b0;
    ready = 1'b1;
    waitCycles(4);
    checkOutput("reset_data",      32'(data0),    32'h0);
    checkOutput("reset_valid",     32'(valid0),   32'h0);
    checkOutput("reset_overrun",   32'(overrun0), 32'h0);
    checkOutput("reset_frame_err", 32'(ferr0),    32'h0);
    checkOutput("reset_valid1",    32'(valid1),   32'h0);
    s_rst = 1'b0;
    waitCycles(6);

    // Single word with the consumer always ready.
    cs0 = 1'b0;
    waitCycles(4);
    applyStimulus(8'hF0, 1'b0);
    modelWord(8'hF0);
    cs0 = 1'b1;
    waitCycles(6);
    checkQueue("t1");
    checkOutput("t1_overrun",   32'(ov_cnt0),   32'(exp_ov0));
    checkOutput("t1_frame_err", 32'(ferr_cnt0), 32'(exp_ferr0));

    // Two words inside one CS assertion.
    cs0 = 1'b0;
    waitCycles(4);
    applyStimulus(8'hA5, 1'b0);
    modelWord(8'hA5);
    applyStimulus(8'h3C, 1'b0);
    modelWord(8'h3C);
    cs0 = 1'b1;
    waitCycles(6);
    checkQueue("t2");

    // Held word, then an overrun, then release by the consumer.
    ready = 1'b0;
    cs0   = 1'b0;
    waitCycles(4);
    applyStimulus(8'h11, 1'b0);
    modelWord(8'h11);
    applyStimulus(8'h22, 1'b0);
    modelWord(8'h22);
    cs0 = 1'b1;
    waitCycles(6);
    checkOutput("t3_data_held", 32'(data0),   32'(model_held));
    checkOutput("t3_valid",     32'(valid0),  32'(model_full));
    checkOutput("t3_overrun",   32'(ov_cnt0), 32'(exp_ov0));
    raiseReady();
    waitCycles(3);
    checkOutput("t3_valid_drop", 32'(valid0), 32'h0);
    checkQueue("t3");

    // Random words with ready changing between words.
    cs0 = 1'b0;
    waitCycles(4);
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(1, 0) == 1) raiseReady();
      else ready = 1'b0;
      w = 8'($urandom);
      applyStimulus(w, 1'b0);
      modelWord(w);
    end
    raiseReady();
    cs0 = 1'b1;
    waitCycles(6);
    checkQueue("rand");
    checkOutput("rand_overrun", 32'(ov_cnt0), 32'(exp_ov0));

    // Aborted frame after three bits, then a good frame.
    cs0 = 1'b0;
    waitCycles(4);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    waitCycles(4);
    cs0 = 1'b1;
    exp_ferr0++;
    waitCycles(6);
    checkOutput("t4_frame_err", 32'(ferr_cnt0), 32'(exp_ferr0));
    checkQueue("t4_partial");
    cs0 = 1'b0;
    waitCycles(4);
    applyStimulus(8'h5A, 1'b0);
    modelWord(8'h5A);
    cs0 = 1'b1;
    waitCycles(6);
    checkQueue("t4");

    // Reset mid-frame; CS stays selected through release, so no frame may start until reselect.
    cs0 = 1'b0;
    waitCycles(4);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b0);
    s_rst = 1'b1;
    waitCycles(2);
    checkOutput("t5_rst_data",      32'(data0),    32'h0);
    checkOutput("t5_rst_valid",     32'(valid0),   32'h0);
    checkOutput("t5_rst_overrun",   32'(overrun0), 32'h0);
    checkOutput("t5_rst_frame_err", 32'(ferr0),    32'h0);
    waitCycles(2);
    s_rst = 1'b0;
    waitCycles(4);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    waitCycles(4);
    cs0 = 1'b1;
    waitCycles(6);
    checkOutput("t5_no_frame_err", 32'(ferr_cnt0), 32'(exp_ferr0));
    cs0 = 1'b0;
    waitCycles(4);
    applyStimulus(8'h81, 1'b0);
    modelWord(8'h81);
    cs0 = 1'b1;
    waitCycles(6);
    checkQueue("t5");
    checkOutput("t5_frame_err", 32'(ferr_cnt0), 32'(exp_ferr0));

    // Active-high CS, falling-edge sampling; all earlier traffic happened with cs1 low.
    checkOutput("t6_ignored_before", 32'(got1.size()), 32'h0);
    cs1 = 1'b1;
    waitCycles(4);
    applyStimulus(8'hC3, 1'b1);
    cs1 = 1'b0;
    waitCycles(6);
    checkOutput("t6_count", 32'(got1.size()), 32'h1);
    if (got1.size() > 0) checkOutput("t6_data", 32'(got1[0]), 32'hC3);
    applyStimulus(8'h96, 1'b1);
    waitCycles(6);
    checkOutput("t6_ignored_after", 32'(got1.size()), 32'h1);
    checkOutput("t6_frame_err",     32'(ferr_cnt1),   32'h0);
    checkOutput("t6_overrun",       32'(ov_cnt1),     32'h0);
    checkQueue("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
